// File: rtl/rv32_decode_pkg.sv
// Shared decode definitions: opcodes, class codes, mnemonic text, immediate formats
// and the decoded record that travels through the stage registers.
package rv32_decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  localparam logic [2:0] CLS_R   = 3'd0;
  localparam logic [2:0] CLS_I   = 3'd1;
  localparam logic [2:0] CLS_S   = 3'd2;
  localparam logic [2:0] CLS_B   = 3'd3;
  localparam logic [2:0] CLS_U   = 3'd4;
  localparam logic [2:0] CLS_J   = 3'd5;
  localparam logic [2:0] CLS_SYS = 3'd6;
  localparam logic [2:0] CLS_ILL = 3'd7;

  typedef logic [47:0] mnem_t;

  localparam mnem_t MN_BLANK  = "      ";
  localparam mnem_t MN_ILL    = "ILL   ";
  localparam mnem_t MN_NOP    = "NOP   ";
  localparam mnem_t MN_LUI    = "LUI   ";
  localparam mnem_t MN_AUIPC  = "AUIPC ";
  localparam mnem_t MN_JAL    = "JAL   ";
  localparam mnem_t MN_JALR   = "JALR  ";
  localparam mnem_t MN_SUB    = "SUB   ";
  localparam mnem_t MN_SRA    = "SRA   ";
  localparam mnem_t MN_SRAI   = "SRAI  ";
  localparam mnem_t MN_FENCE  = "FENCE ";
  localparam mnem_t MN_ECALL  = "ECALL ";
  localparam mnem_t MN_EBREAK = "EBREAK";

  // Tables indexed by funct3; element [7] is listed first.
  localparam mnem_t [7:0] MN_BRANCH = {"BGEU  ", "BLTU  ", "BGE   ", "BLT   ",
                                       "ILL   ", "ILL   ", "BNE   ", "BEQ   "};
  localparam mnem_t [7:0] MN_LOAD   = {"ILL   ", "ILL   ", "LHU   ", "LBU   ",
                                       "ILL   ", "LW    ", "LH    ", "LB    "};
  localparam mnem_t [7:0] MN_STORE  = {"ILL   ", "ILL   ", "ILL   ", "ILL   ",
                                       "ILL   ", "SW    ", "SH    ", "SB    "};
  localparam mnem_t [7:0] MN_OPIMM  = {"ANDI  ", "ORI   ", "SRLI  ", "XORI  ",
                                       "SLTIU ", "SLTI  ", "SLLI  ", "ADDI  "};
  localparam mnem_t [7:0] MN_OP     = {"AND   ", "OR    ", "SRL   ", "XOR   ",
                                       "SLTU  ", "SLT   ", "SLL   ", "ADD   "};
  localparam mnem_t [7:0] MN_MULDIV = {"REMU  ", "REM   ", "DIVU  ", "DIV   ",
                                       "MULHU ", "MULHSU", "MULH  ", "MUL   "};

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT
  } imm_fmt_e;

  typedef struct packed {
    logic [31:0] pc;
    mnem_t       mnem;
    logic [2:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        illegal;
  } dec_rec_t;

  localparam dec_rec_t REC_RESET = '{pc: 32'd0, mnem: MN_BLANK, cls: CLS_R, rd: 5'd0,
                                     rs1: 5'd0, rs2: 5'd0, funct3: 3'd0, imm: 32'd0,
                                     illegal: 1'b0};

  function automatic logic [31:0] build_imm(input imm_fmt_e fmt, input logic [31:0] w);
    case (fmt)
      IMM_I:     return {{20{w[31]}}, w[31:20]};
      IMM_S:     return {{20{w[31]}}, w[31:25], w[11:7]};
      IMM_B:     return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      IMM_U:     return {w[31:12], 12'd0};
      IMM_J:     return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      IMM_SHAMT: return {27'd0, w[24:20]};
      default:   return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_decode_comb.sv
// Purely combinational RV32I(+M) word decoder producing one decoded record.
module rv32i_decode_comb
  import rv32_decode_pkg::*;
#(
  parameter int EN_RV32M = 0
) (
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output dec_rec_t    rec
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       ill;
  mnem_t      mnem;
  logic [2:0] cls;
  imm_fmt_e   fmt;
  logic       use_rd, use_rs1, use_rs2;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    ill     = 1'b0;
    mnem    = MN_ILL;
    cls     = CLS_ILL;
    fmt     = IMM_NONE;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OPC_LUI:   begin mnem = MN_LUI;   cls = CLS_U; fmt = IMM_U; use_rd = 1'b1; end
      OPC_AUIPC: begin mnem = MN_AUIPC; cls = CLS_U; fmt = IMM_U; use_rd = 1'b1; end
      OPC_JAL:   begin mnem = MN_JAL;   cls = CLS_J; fmt = IMM_J; use_rd = 1'b1; end
      OPC_JALR: begin
        mnem = MN_JALR; cls = CLS_I; fmt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1;
        ill  = (f3 != 3'd0);
      end
      OPC_BRANCH: begin
        mnem = MN_BRANCH[f3]; cls = CLS_B; fmt = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1;
        ill  = (f3 == 3'd2) || (f3 == 3'd3);
      end
      OPC_LOAD: begin
        mnem = MN_LOAD[f3]; cls = CLS_I; fmt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1;
        ill  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      OPC_STORE: begin
        mnem = MN_STORE[f3]; cls = CLS_S; fmt = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
        ill  = (f3 > 3'd2);
      end
      OPC_OPIMM: begin
        mnem = MN_OPIMM[f3]; cls = CLS_I; fmt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1;
        if (f3 == 3'd1) begin
          fmt = IMM_SHAMT;
          ill = (f7 != F7_BASE);
        end else if (f3 == 3'd5) begin
          fmt = IMM_SHAMT;
          if (f7 == F7_ALT) mnem = MN_SRAI;
          else              ill  = (f7 != F7_BASE);
        end
        if (instr == 32'h0000_0013) mnem = MN_NOP;
      end
      OPC_OP: begin
        cls = CLS_R; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        if (f7 == F7_BASE)                        mnem = MN_OP[f3];
        else if (f7 == F7_ALT && f3 == 3'd0)      mnem = MN_SUB;
        else if (f7 == F7_ALT && f3 == 3'd5)      mnem = MN_SRA;
        else if (f7 == F7_MULDIV && EN_RV32M != 0) mnem = MN_MULDIV[f3];
        else                                      ill  = 1'b1;
      end
      OPC_MISC: begin
        mnem = MN_FENCE; cls = CLS_SYS; fmt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1;
      end
      OPC_SYSTEM: begin
        cls = CLS_SYS; fmt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1;
        // Only the two fully-zero-field encodings are recognised; no CSR support.
        if (instr[31:7] == 25'd0)               mnem = MN_ECALL;
        else if (instr[31:7] == 25'h000_2000)   mnem = MN_EBREAK;
        else                                    ill  = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (instr == 32'h0000_0000 || instr == 32'hFFFF_FFFF) ill = 1'b1;
    if (ill) begin
      mnem    = MN_ILL;
      cls     = CLS_ILL;
      fmt     = IMM_NONE;
      use_rd  = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
    end
  end

  assign rec.pc      = pc;
  assign rec.mnem    = mnem;
  assign rec.cls     = cls;
  assign rec.rd      = use_rd  ? instr[11:7]  : 5'd0;
  assign rec.rs1     = use_rs1 ? instr[19:15] : 5'd0;
  assign rec.rs2     = use_rs2 ? instr[24:20] : 5'd0;
  assign rec.funct3  = f3;
  assign rec.imm     = build_imm(fmt, instr);
  assign rec.illegal = ill;

endmodule

// File: rtl/rv32i_decode_stage.sv
// Handshaked decode stage: input decoder, main register plus one-entry skid,
// branch-redirect flush and saturating consume/illegal statistics.
module rv32i_decode_stage
  import rv32_decode_pkg::*;
#(
  parameter int CHAR_W   = 6,
  parameter int EN_RV32M = 0,
  parameter int CNT_W    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [31:0]           in_pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_pc,
  output logic [8*CHAR_W-1:0]   out_mnem,
  output logic [2:0]            out_class,
  output logic [4:0]            out_rd,
  output logic [4:0]            out_rs1,
  output logic [4:0]            out_rs2,
  output logic [2:0]            out_funct3,
  output logic [31:0]           out_imm,
  output logic                  out_illegal,
  output logic [CNT_W-1:0]      decode_count,
  output logic [CNT_W-1:0]      illegal_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  dec_rec_t dec_rec, main_rec, skid_rec;
  logic     main_valid, skid_valid;
  logic     accept, consume;

  rv32i_decode_comb #(.EN_RV32M(EN_RV32M)) u_decode (
    .instr (in_instr),
    .pc    (in_pc),
    .rec   (dec_rec)
  );

  // in_ready comes straight from the skid flag, so it is a registered signal.
  assign in_ready = ~skid_valid;
  assign accept   = in_valid && in_ready;
  assign consume  = main_valid && out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_rec   <= REC_RESET;
      skid_rec   <= REC_RESET;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (consume) begin
        main_rec   <= skid_rec;
        skid_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid || consume) begin
        main_rec   <= dec_rec;
        main_valid <= 1'b1;
      end else begin
        skid_rec   <= dec_rec;
        skid_valid <= 1'b1;
      end
    end else if (consume) begin
      main_valid <= 1'b0;
    end
  end

  // Statistics follow consumption only; flush never touches them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      decode_count  <= '0;
      illegal_count <= '0;
    end else if (consume) begin
      if (decode_count != '1) decode_count <= decode_count + CNT_ONE;
      if (main_rec.illegal && illegal_count != '1) illegal_count <= illegal_count + CNT_ONE;
    end
  end

  assign out_valid   = main_valid;
  assign out_pc      = main_rec.pc;
  assign out_class   = main_rec.cls;
  assign out_rd      = main_rec.rd;
  assign out_rs1     = main_rec.rs1;
  assign out_rs2     = main_rec.rs2;
  assign out_funct3  = main_rec.funct3;
  assign out_imm     = main_rec.imm;
  assign out_illegal = main_rec.illegal;

  generate
    if (CHAR_W > 6) begin : g_pad
      assign out_mnem = {main_rec.mnem, {(CHAR_W-6){8'h20}}};
    end else begin : g_nopad
      assign out_mnem = main_rec.mnem;
    end
  endgenerate

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Randomised scoreboard bench for rv32i_decode_stage: a base instance and an
// RV32M instance with a wider mnemonic and 4-bit counters share one stimulus stream.
module tb_rv32i_decode_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [31:0] in_instr = 32'd0, in_pc = 32'd0;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [47:0] out_mnem;
  logic [2:0]  out_class, out_funct3;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [15:0] decode_count, illegal_count;

  logic        m_in_ready, m_out_valid, m_out_illegal;
  logic [31:0] m_out_pc, m_out_imm;
  logic [63:0] m_out_mnem;
  logic [2:0]  m_out_class, m_out_funct3;
  logic [4:0]  m_out_rd, m_out_rs1, m_out_rs2;
  logic [3:0]  m_decode_count, m_illegal_count;

  rv32i_decode_stage dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_mnem(out_mnem), .out_class(out_class),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
    .out_imm(out_imm), .out_illegal(out_illegal), .decode_count(decode_count),
    .illegal_count(illegal_count)
  );

  rv32i_decode_stage #(.CHAR_W(8), .EN_RV32M(1), .CNT_W(4)) dut_m (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(m_out_valid),
    .out_ready(out_ready), .out_pc(m_out_pc), .out_mnem(m_out_mnem), .out_class(m_out_class),
    .out_rd(m_out_rd), .out_rs1(m_out_rs1), .out_rs2(m_out_rs2), .out_funct3(m_out_funct3),
    .out_imm(m_out_imm), .out_illegal(m_out_illegal), .decode_count(m_decode_count),
    .illegal_count(m_illegal_count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  string n_br[8] = '{"BEQ", "BNE", "?", "?", "BLT", "BGE", "BLTU", "BGEU"};
  string n_ld[8] = '{"LB", "LH", "LW", "?", "LBU", "LHU", "?", "?"};
  string n_st[8] = '{"SB", "SH", "SW", "?", "?", "?", "?", "?"};
  string n_oi[8] = '{"ADDI", "SLLI", "SLTI", "SLTIU", "XORI", "SRLI", "ORI", "ANDI"};
  string n_op[8] = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};
  string n_md[8] = '{"MUL", "MULH", "MULHSU", "MULHU", "DIV", "DIVU", "REM", "REMU"};

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    if (v >= (32'd1 << (bits - 1))) return v - (32'd1 << bits);
    return v;
  endfunction

  function automatic void ref_dec(input logic [31:0] w, input bit en_m, output string mn,
                                  output int cls, output logic [4:0] rd, output logic [4:0] rs1,
                                  output logic [4:0] rs2, output logic [31:0] imm);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    byte        fmt;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    mn = "ILL"; fmt = "-";
    case (op)
      7'h37: begin mn = "LUI";   fmt = "U"; end
      7'h17: begin mn = "AUIPC"; fmt = "U"; end
      7'h6F: begin mn = "JAL";   fmt = "J"; end
      7'h67: if (f3 == 0) begin mn = "JALR"; fmt = "I"; end
      7'h63: if (f3 != 2 && f3 != 3) begin mn = n_br[f3]; fmt = "B"; end
      7'h03: if (f3 != 3 && f3 != 6 && f3 != 7) begin mn = n_ld[f3]; fmt = "I"; end
      7'h23: if (f3 <= 2) begin mn = n_st[f3]; fmt = "S"; end
      7'h13: begin
        if (f3 == 1) begin
          if (f7 == 0) begin mn = "SLLI"; fmt = "H"; end
        end else if (f3 == 5) begin
          if (f7 == 0)         begin mn = "SRLI"; fmt = "H"; end
          else if (f7 == 7'h20) begin mn = "SRAI"; fmt = "H"; end
        end else begin
          mn = n_oi[f3]; fmt = "I";
        end
        if (w == 32'h13) mn = "NOP";
      end
      7'h33: begin
        if (f7 == 0)                       begin mn = n_op[f3]; fmt = "R"; end
        else if (f7 == 7'h20 && f3 == 0)   begin mn = "SUB"; fmt = "R"; end
        else if (f7 == 7'h20 && f3 == 5)   begin mn = "SRA"; fmt = "R"; end
        else if (f7 == 7'h01 && en_m)      begin mn = n_md[f3]; fmt = "R"; end
      end
      7'h0F: begin mn = "FENCE"; fmt = "Y"; end
      7'h73: begin
        if (w[31:7] == 25'd0)            begin mn = "ECALL";  fmt = "Y"; end
        else if (w == 32'h0010_0073)     begin mn = "EBREAK"; fmt = "Y"; end
      end
      default: ;
    endcase
    if (w == 32'd0 || w == 32'hFFFF_FFFF) begin mn = "ILL"; fmt = "-"; end
    case (fmt)
      "R": cls = 0;  "I", "H": cls = 1;  "S": cls = 2;  "B": cls = 3;
      "U": cls = 4;  "J": cls = 5;       "Y": cls = 6;  default: cls = 7;
    endcase
    rd  = (fmt inside {"R", "I", "H", "U", "J", "Y"}) ? w[11:7] : 5'd0;
    rs1 = (fmt inside {"R", "I", "H", "S", "B", "Y"}) ? w[19:15] : 5'd0;
    rs2 = (fmt inside {"R", "S", "B"}) ? w[24:20] : 5'd0;
    case (fmt)
      "I", "Y": imm = sext(32'(w[31:20]), 12);
      "H":      imm = 32'(w[24:20]);
      "S":      imm = sext(32'(w[31:25]) * 32 + 32'(w[11:7]), 12);
      "B":      imm = sext(32'(w[31]) * 4096 + 32'(w[7]) * 2048 + 32'(w[30:25]) * 32
                           + 32'(w[11:8]) * 2, 13);
      "U":      imm = w & 32'hFFFF_F000;
      "J":      imm = sext(32'(w[31]) * (1 << 20) + 32'(w[19:12]) * 4096 + 32'(w[20]) * 2048
                           + 32'(w[30:21]) * 2, 21);
      default:  imm = 32'd0;
    endcase
  endfunction

  function automatic logic [63:0] mn_bits(input string s, input int n);
    logic [63:0] r;
    byte c;
    r = 64'd0;
    for (int i = 0; i < n; i++) begin
      c = (i < s.len()) ? s[i] : 8'h20;
      r = {r[55:0], c};
    end
    return r;
  endfunction

  typedef struct { logic [31:0] w; logic [31:0] pc; } ent_t;
  ent_t        q[$];
  int unsigned dcnt = 0, icnt = 0, mdcnt = 0, micnt = 0;
  logic [31:0] pc_next = 32'h0000_1000;

  // One clock of stimulus; entry-level expectations come from the queue model.
  task automatic step(input logic v, input logic [31:0] w, input logic r, input logic f);
    string mn, mn_m;
    int cls, cls_m;
    logic [4:0] rd, rs1, rs2, x1, x2, x3;
    logic [31:0] imm, xi;
    bit acc, cons;
    in_valid = v; in_instr = w; in_pc = pc_next; out_ready = r; flush = f;
    check_eq("in_ready", in_ready, q.size() < 2);
    check_eq("out_valid", out_valid, q.size() > 0);
    check_eq("m_in_ready", m_in_ready, q.size() < 2);
    check_eq("decode_count", decode_count, dcnt);
    check_eq("illegal_count", illegal_count, icnt);
    check_eq("m_decode_count", m_decode_count, mdcnt);
    check_eq("m_illegal_count", m_illegal_count, micnt);
    acc  = v && (q.size() < 2);
    cons = r && (q.size() > 0);
    if (q.size() > 0) begin
      ref_dec(q[0].w, 1'b0, mn, cls, rd, rs1, rs2, imm);
      ref_dec(q[0].w, 1'b1, mn_m, cls_m, x1, x2, x3, xi);
      check_eq("pc", out_pc, q[0].pc);
      check_eq("mnem", out_mnem, mn_bits(mn, 6));
      check_eq("class", out_class, cls);
      check_eq("rd", out_rd, rd);
      check_eq("rs1", out_rs1, rs1);
      check_eq("rs2", out_rs2, rs2);
      check_eq("funct3", out_funct3, q[0].w[14:12]);
      check_eq("imm", out_imm, imm);
      check_eq("illegal", out_illegal, cls == 7);
      check_eq("m_mnem", m_out_mnem, mn_bits(mn_m, 8));
      check_eq("m_illegal", m_out_illegal, cls_m == 7);
      if (cons) begin
        $display("xfer pc=%08h instr=%08h %-6s class=%0d imm=%08h", q[0].pc, q[0].w, mn, cls, imm);
        if (dcnt < 65535) dcnt++;
        if (cls == 7 && icnt < 65535) icnt++;
        if (mdcnt < 15) mdcnt++;
        if (cls_m == 7 && micnt < 15) micnt++;
      end
    end
    @(posedge clock); #1;
    if (cons) void'(q.pop_front());
    if (f) q.delete();
    else if (acc) q.push_back('{w: w, pc: pc_next});
    if (acc) pc_next += 32'd4;
  endtask

  logic [6:0] opc_tab[11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13,
                              7'h33, 7'h0F, 7'h73};

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 15);
    if (k < 11) begin
      w[6:0] = opc_tab[k];
      if (w[6:0] == 7'h33 || (w[6:0] == 7'h13 && (w[14:12] == 3'd1 || w[14:12] == 3'd5))) begin
        case ($urandom_range(0, 3))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          2: w[31:25] = 7'h01;
          default: ;
        endcase
      end
      if (w[6:0] == 7'h73) begin
        case ($urandom_range(0, 2))
          0: w = 32'h0000_0073;
          1: w = 32'h0010_0073;
          default: ;
        endcase
      end
    end else if (k == 11) w = 32'h0000_0000;
    else if (k == 12)     w = 32'hFFFF_FFFF;
    else if (k == 13)     w = 32'h0000_0013;
    return w;
  endfunction

  task automatic model_reset();
    q.delete();
    dcnt = 0; icnt = 0; mdcnt = 0; micnt = 0;
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 24) == 0);
  endtask

  int unsigned ib;

  initial begin
    #12;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_mnem", out_mnem, "      ");
    check_eq("rst_m_mnem", m_out_mnem, "        ");
    check_eq("rst_imm", out_imm, 32'd0);
    check_eq("rst_pc", out_pc, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Directed stream at full throughput.
    step(1'b1, 32'h00A0_0093, 1'b1, 1'b0);
    check_eq("t1_addi_mnem", out_mnem, "ADDI  ");
    check_eq("t1_addi_imm", out_imm, 32'd10);
    check_eq("t1_addi_rd", out_rd, 5'd1);
    step(1'b1, 32'h4020_8133, 1'b1, 1'b0);
    check_eq("t1_sub_mnem", out_mnem, "SUB   ");
    check_eq("t1_sub_rd", out_rd, 5'd2);
    check_eq("t1_sub_rs2", out_rs2, 5'd2);
    step(1'b1, 32'h0000_0013, 1'b1, 1'b0);
    check_eq("t1_nop_mnem", out_mnem, "NOP   ");
    check_eq("t1_nop_class", out_class, 3'd1);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Back-pressure: second accept fills the skid.
    step(1'b1, 32'h0010_0113, 1'b0, 1'b0);
    step(1'b1, 32'h0020_0193, 1'b0, 1'b0);
    check_eq("t2_in_ready_low", in_ready, 1'b0);
    step(1'b1, 32'h0030_0213, 1'b0, 1'b0);
    step(1'b1, 32'h0030_0213, 1'b1, 1'b0);
    step(1'b1, 32'h0030_0213, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Flush with skid full, then flush beating a live accept.
    step(1'b1, 32'h0040_0293, 1'b0, 1'b0);
    step(1'b1, 32'h0050_0313, 1'b0, 1'b0);
    step(1'b1, 32'h0060_0393, 1'b0, 1'b1);
    check_eq("t3_flush_valid", out_valid, 1'b0);
    check_eq("t3_flush_ready", in_ready, 1'b1);
    step(1'b1, 32'h0070_0413, 1'b1, 1'b1);
    check_eq("t3_flush_drop", out_valid, 1'b0);
    step(1'b1, 32'h0080_0493, 1'b1, 1'b0);
    check_eq("t3_after_pc", out_pc, pc_next - 32'd4);

    // Immediate boundaries.
    step(1'b1, 32'hFE00_0EE3, 1'b1, 1'b0);
    check_eq("t4_beq_class", out_class, 3'd3);
    check_eq("t4_beq_imm", out_imm, 32'hFFFF_FFFC);
    step(1'b1, 32'hFFF0_0067, 1'b1, 1'b0);
    check_eq("t4_jalr_imm", out_imm, 32'hFFFF_FFFF);

    // MUL encoding: illegal without M, named with M.
    step(1'b1, 32'h0220_8033, 1'b1, 1'b0);
    check_eq("t5_mul_illegal", out_illegal, 1'b1);
    check_eq("t5_mul_mnem_m", m_out_mnem, "MUL     ");
    ib = icnt;
    step(1'b0, 32'd0, 1'b1, 1'b0);
    check_eq("t5_illegal_count", illegal_count, ib + 1);

    random_phase(500);

    // Asynchronous reset between edges with entries held.
    step(1'b1, 32'h0000_0013, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0013, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_eq("t6_valid", out_valid, 1'b0);
    check_eq("t6_ready", in_ready, 1'b1);
    check_eq("t6_dcount", decode_count, 16'd0);
    check_eq("t6_icount", illegal_count, 16'd0);
    check_eq("t6_mnem", out_mnem, "      ");
    check_eq("t6_m_dcount", m_decode_count, 4'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    random_phase(150);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
